// File: rtl/mbm_pkg.sv
// mbm_pkg: widths, default bias and stage records shared by the Mitchell multiplier pipeline.
package mbm_pkg;
  localparam int OW = 8;
  localparam int PW = 16;
  localparam int FW = 7;
  localparam int LW = 3;
  localparam int KW = 4;
  localparam int SW = 9;
  localparam logic [FW-1:0] BIAS_DEF = 7'd8;
  typedef struct packed {
    logic zero;
    logic [LW-1:0] k_a;
    logic [LW-1:0] k_b;
    logic [FW-1:0] x_a;
    logic [FW-1:0] x_b;
  } s1_t;
  typedef struct packed {
    logic zero;
    logic [KW-1:0] k;
    logic [SW-1:0] sum;
  } s2_t;
endpackage

// File: rtl/lod.sv
// lod: leading-one detector, returns the index of the highest set bit (0 for a zero input).
module lod
  import mbm_pkg::*;
(
  input  logic [OW-1:0] value,
  output logic [LW-1:0] pos
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < OW; i++) if (value[i]) pos = LW'(i);
  end
endmodule

// File: rtl/mbm_mult_pipe.sv
// mbm_mult_pipe: 3-stage minimally biased Mitchell log multiplier with valid/ready flow control.
// Define MBM_BIAS_EN to add BIAS to the fraction sum; otherwise plain Mitchell.
module mbm_mult_pipe
  import mbm_pkg::*;
#(
  parameter logic [FW-1:0] BIAS = BIAS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [OW-1:0] in_a,
  input  logic [OW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_product
);
  logic v1, v2, v3, ld1, ld2, ld3, carry;
  s1_t s1, s1_d;
  s2_t s2, s2_d;
  logic [LW-1:0] k_a, k_b;
  logic [FW-1:0] bias_eff;
  logic [OW-1:0] mant;
  logic [KW-1:0] ex;
  logic [PW-1:0] prod_d;
  lod u_lod_a (.value(in_a), .pos(k_a));
  lod u_lod_b (.value(in_b), .pos(k_b));
`ifdef MBM_BIAS_EN
  assign bias_eff = BIAS;
`else
  assign bias_eff = {FW{1'b0}} & BIAS;
`endif
  // each stage loads when empty or when it drains downstream this cycle
  assign ld3 = !v3 | out_ready;
  assign ld2 = !v2 | ld3;
  assign ld1 = !v1 | ld2;
  assign in_ready = !rst & ld1;
  assign out_valid = v3;
  always_comb begin
    s1_d.zero = (in_a == '0) | (in_b == '0);
    s1_d.k_a = k_a;
    s1_d.k_b = k_b;
    s1_d.x_a = FW'(in_a << (LW'(OW-1) - k_a));
    s1_d.x_b = FW'(in_b << (LW'(OW-1) - k_b));
    s2_d.zero = s1.zero;
    s2_d.k = KW'(s1.k_a) + KW'(s1.k_b);
    s2_d.sum = SW'(s1.x_a) + SW'(s1.x_b) + SW'(bias_eff);
    carry = s2.sum[SW-1:FW] != '0;
    mant = carry ? (s2.sum[SW-1] ? {OW{1'b1}} : s2.sum[OW-1:0]) : {1'b1, s2.sum[FW-1:0]};
    ex = carry ? s2.k + 1'b1 : s2.k;
    prod_d = s2.zero ? '0 : PW'(((PW+FW)'(mant) << ex) >> FW);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_product <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (ld3 & v2) out_product <= prod_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ld1 & in_valid) s1 <= s1_d;
    if (ld2 & v1) s2 <= s2_d;
  end
endmodule

// File: tb/tb_mbm_mult_pipe.sv
// tb_mbm_mult_pipe: scoreboard bench for mbm_mult_pipe against an arithmetic Mitchell model.
module tb_mbm_mult_pipe;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [7:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid;
  logic [15:0] out_product;
  typedef struct {
    logic [15:0] exp;
    int cyc;
    bit lat;
  } item_t;
  item_t sbq[$];
  item_t mit;
  int chk = 0, err = 0, cyc = 0;
  bit held_v = 0, done = 0;
  logic [15:0] held;
`ifdef MBM_BIAS_EN
  localparam int BIAS = 8;
`else
  localparam int BIAS = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mbm_mult_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int msb(input int v);
    int k = 0;
    while ((1 << (k + 1)) <= v) k++;
    return k;
  endfunction

  // a = 2^ka * (1 + fa/128); product approximated as 2^(ka+kb) * (1 + fa/128 + fb/128 + bias)
  function automatic logic [15:0] model(input int a, input int b);
    int ka, kb, fa, fb, s, m, e;
    if (a == 0 || b == 0) return 16'd0;
    ka = msb(a);
    kb = msb(b);
    fa = (a - (1 << ka)) * 128 / (1 << ka);
    fb = (b - (1 << kb)) * 128 / (1 << kb);
    s = fa + fb + BIAS;
    if (s >= 128) begin
      m = (s > 255) ? 255 : s;
      e = ka + kb + 1;
    end else begin
      m = 128 + s;
      e = ka + kb;
    end
    return 16'((m * (1 << e)) / 128);
  endfunction

  always @(negedge clk) begin
    if (rst) held_v = 0;
    else if (out_valid) begin
      if (held_v) check("stall_hold", out_product, held);
      if (out_ready) begin
        held_v = 0;
        if (sbq.size() == 0) begin
          chk++;
          err++;
          $display("FAIL unexpected_product actual=%0d expected=none", out_product);
        end else begin
          mit = sbq.pop_front();
          check("product", out_product, mit.exp);
          if (mit.lat) check("latency", cyc - mit.cyc, 3);
        end
      end else begin
        held_v = 1;
        held = out_product;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input bit lat);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk++;
      err++;
      $display("FAIL accept_timeout actual=blocked expected=accepted");
    end else sbq.push_back('{exp, cyc, lat});
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic send_rand();
    logic [7:0] a, b;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    send(a, b, model(a, b), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk++;
      err++;
      $display("FAIL drain_timeout actual=%0d expected=0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
`ifdef MBM_BIAS_EN
    send(12, 10, 116, 1);
    drain();
    send(255, 255, 65280, 0);
`else
    send(12, 10, 112, 1);
    drain();
    send(255, 255, 65024, 0);
`endif
    send(1, 1, 1, 0);
    send(0, 200, 0, 0);
    send(200, 0, 0, 0);
    drain();
    t0 = cyc;
    repeat (20) send_rand();
    check("throughput", cyc - t0, 20);
    drain();
    out_ready = 0;
    fork
      repeat (4) send_rand();
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send_rand();
          n = $urandom_range(0, 2);
          if (n != 0) begin
            repeat (n) @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1;
    drain();
    send_rand();
    send_rand();
    rst = 1;
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_product", out_product, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("midrst_in_ready_after", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    send(3, 5, 14, 1);
    drain();
    check("queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
